// File: rtl/divider_restoring_32_pkg.sv
// Shared constants for the restoring divider: FSM encoding and default operand width.
package divider_restoring_32_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/divider_restoring_32_subtractor.sv
// W-bit subtractor a - b built as a + ~b + 1 on a Kogge-Stone generate/propagate prefix tree.
module subtractor_with_tree_borrow #(
  parameter int W = 33
) (
  output logic [W-1:0] diff,
  output logic         borrow,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b
);
  localparam int L = (W > 1) ? $clog2(W) : 1;
  localparam logic CIN = 1'b1;

  logic [L:0][W-1:0] g, p;
  logic [W:0]        c;

  assign g[0] = a & ~b;
  assign p[0] = a ^ ~b;

  // Group (g,p) at level l covers bits [i : i-2^l+1]; low bits pass through once they reach bit 0.
  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_comb
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign c[0] = CIN;
  for (genvar i = 0; i < W; i++) begin : g_carry
    assign c[i+1] = g[L][i] | (p[L][i] & CIN);
  end

  assign diff   = p[0] ^ c[W-1:0];
  assign borrow = ~c[W];
endmodule

// File: rtl/divider_restoring_32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
module divider_restoring_32
  import divider_restoring_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q, d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial_a, trial_b, diff, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             borrow, fits;

  assign trial_a = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial_b = {1'b0, d};

  subtractor_with_tree_borrow #(.W(WIDTH + 1)) u_sub (
    .diff   (diff),
    .borrow (borrow),
    .a      (trial_a),
    .b      (trial_b)
  );

  // r[WIDTH] would mean the shifted partial remainder already exceeds D; it stays 0 while R < D.
  assign fits  = ~borrow | r[WIDTH];
  assign r_nxt = fits ? diff : trial_a;
  assign q_nxt = {q[WIDTH-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            q        <= dividend;
            d        <= divisor;
            r        <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          r     <= r_nxt;
          q     <= q_nxt;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
